i2c_bit_controller: RTL and testbench
=====================================

Name: i2c_bit_controller

Overview:
- Bit-level I2C engine directly downstream of clock_divisor; consumes its divided output as a one-clk_i-cycle quarter-period strobe (tick_i).
- Executes one START, STOP, WRITE-bit or READ-bit command per handshake. Each command spans exactly 4 quarter-phases and drives open-drain SCL/SDA release levels.
- Feeds the byte-level controller above it, which issues commands and collects read bits.

Parameters:
- SYNC_STAGES, 2, flop stages on the scl_i/sda_i synchronizers (minimum 2)

Ports:
- clk_i  input  1  system clock, same clock as clock_divisor
- rst_i  input  1  reset, synchronous, active-high
- tick_i  input  1  quarter-bit strobe from clock_divisor; one clk_i cycle wide
- cmd_valid_i  input  1  command request
- cmd_ready_o  output  1  block idle, can accept a command
- cmd_i  input  2  command code (encodings in the package)
- bit_i  input  1  data bit for WRITE
- done_o  output  1  one-cycle pulse at command completion
- bit_o  output  1  sampled SDA for READ; holds until the next READ completes
- bus_owned_o  output  1  set by START completion, cleared by STOP completion
- scl_o  output  1  SCL level; 1 = release, 0 = drive low
- sda_o  output  1  SDA level; 1 = release, 0 = drive low
- scl_i  input  1  SCL bus level (async)
- sda_i  input  1  SDA bus level (async)

Behaviour:
- Reset (rst_i high at a posedge clk_i): state IDLE, phase counter 0, scl_o=1, sda_o=1, cmd_ready_o=1, done_o=0, bit_o=0, bus_owned_o=0. Reset mid-command aborts with no done_o pulse.
- States: IDLE, BUSY. A 2-bit quarter counter q runs 0..3 in BUSY.
- Accept: cmd_valid_i & cmd_ready_o at a posedge. Next cycle: BUSY, q=0, cmd_ready_o=0, and Q0 levels driven. A tick_i in the accept cycle is not counted.
- In BUSY, each tick_i advances q. The tick_i received in Q3 completes the command: next cycle done_o=1, state IDLE, cmd_ready_o=1. Q0 therefore lasts between 1 and one tick period.
- cmd_valid_i while BUSY is ignored. A new command may be accepted in the same cycle done_o is high.
- Levels as (scl_o, sda_o) per Q0/Q1/Q2/Q3, registered; they hold after completion until the next command:
  - START: (hold, 1) / (1, 1) / (1, 0) / (0, 0). "hold" keeps the current scl_o, so idle and repeated start both work.
  - STOP: (0, 0) / (1, 0) / (1, 1) / (1, 1).
  - WRITE: (0, b) / (1, b) / (1, b) / (0, b), with b = bit_i latched at accept.
  - READ: (0, 1) / (1, 1) / (1, 1) / (0, 1). Synchronized sda is latched into bit_o on the tick_i ending Q1.
- bit_o updates only on READ. bus_owned_o updates when START or STOP completes.
- scl_i and sda_i always pass through SYNC_STAGES flops; only the synchronized values are used.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined: in Q1 and Q2, a tick_i is ignored (q does not advance) while synchronized scl_i=0. This holds the phase until the target releases SCL; there is no timeout.
- Undefined: scl_i is unused and ticks always advance q.

Decomposition:
- Package i2c_pkg holds:
  - command codes CMD_START=2'b00, CMD_STOP=2'b01, CMD_WRITE=2'b10, CMD_READ=2'b11;
  - state enum IDLE/BUSY;
  - quarter-index constants Q0..Q3.
- Sub-module i2c_sync: a SYNC_STAGES-deep synchronizer with reset value 1, instantiated for scl_i and sda_i.

Test Plan:
- Reset, then 10 idle cycles -> scl_o=1, sda_o=1, cmd_ready_o=1, done_o never pulses.
- tick_i every 5 clk_i cycles; START -> sda_o falls while scl_o=1 (Q2), then scl_o=0 (Q3); done_o after the 4th counted tick; bus_owned_o=1.
- WRITE 1,0,1,1,0,0,1,0 back-to-back (new command accepted on each done_o cycle) -> sda_o stable through each scl_o high window; 8 done_o pulses, 32 ticks total.
- READ with sda_i driven 0 -> bit_o=0 at done_o; READ with sda_i=1 -> bit_o=1.
- STOP -> sda_o rises while scl_o=1; bus_owned_o=0; final (scl_o, sda_o)=(1,1). Then a repeated START with scl_o=0 held in Q0 -> correct Q1..Q3 sequence.
- Assert rst_i during Q2 of a WRITE -> next cycle scl_o=sda_o=1, IDLE, no done_o. With I2C_CLOCK_STRETCH_EN, hold scl_i=0 for 12 ticks in Q1 -> q frozen; completes 3 ticks after release.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C bit engine: command codes, FSM states, quarter indices
// and the per-quarter SCL/SDA level table.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Returns {scl, sda} release levels for quarter q of a command.
  // START Q0 keeps the present SCL so both idle and repeated starts are legal.
  function automatic logic [1:0] quarter_levels(input cmd_e cmd, input logic [1:0] q,
                                                input logic b, input logic scl_cur);
    logic [1:0] lv;
    lv = 2'b11;
    case (cmd)
      CMD_START: begin
        case (q)
          Q0:      lv = {scl_cur, 1'b1};
          Q1:      lv = 2'b11;
          Q2:      lv = 2'b10;
          default: lv = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (q)
          Q0:      lv = 2'b00;
          Q1:      lv = 2'b10;
          default: lv = 2'b11;
        endcase
      end
      CMD_WRITE: begin
        if (q == Q0 || q == Q3) lv = {1'b0, b};
        else                    lv = {1'b1, b};
      end
      default: begin
        if (q == Q0 || q == Q3) lv = 2'b01;
        else                    lv = 2'b11;
      end
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop synchronizer for an asynchronous bus line; resets to the released level (1).
// Latency STAGES clocks; no flow control.
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_ff <= '1;
    else       r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/i2c_bit_controller.sv
// I2C bit engine: one START/STOP/WRITE/READ per handshake, four tick-paced quarters each.
// Optional SCL clock stretching in Q1/Q2 when I2C_CLOCK_STRETCH_EN is defined.
module i2c_bit_controller
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       bit_i,
  output logic       done_o,
  output logic       bit_o,
  output logic       bus_owned_o,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  logic   w_scl_sync;
  logic   w_sda_sync;
  logic   w_stall;
  logic   w_adv;
  state_e r_state;
  logic [1:0] r_q;
  cmd_e   r_cmd;
  logic   r_b;
  logic   r_scl;
  logic   r_sda;
  logic   r_done;
  logic   r_bit;
  logic   r_owned;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (scl_i),
    .o_q   (w_scl_sync)
  );

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (sda_i),
    .o_q   (w_sda_sync)
  );

`ifdef I2C_CLOCK_STRETCH_EN
  // A target holding SCL low during the high quarters freezes the phase.
  assign w_stall = (r_q == Q1 || r_q == Q2) && !w_scl_sync;
`else
  logic w_unused_scl;
  assign w_unused_scl = w_scl_sync;
  assign w_stall      = 1'b0;
`endif

  assign w_adv = tick_i && (r_state == BUSY) && !w_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_q     <= Q0;
      r_cmd   <= CMD_START;
      r_b     <= 1'b0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
      r_done  <= 1'b0;
      r_bit   <= 1'b0;
      r_owned <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_state        <= BUSY;
            r_q            <= Q0;
            r_cmd          <= cmd_e'(cmd_i);
            r_b            <= bit_i;
            {r_scl, r_sda} <= quarter_levels(cmd_e'(cmd_i), Q0, bit_i, r_scl);
          end
        end
        BUSY: begin
          if (w_adv) begin
            if (r_q == Q3) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              if (r_cmd == CMD_START) r_owned <= 1'b1;
              if (r_cmd == CMD_STOP)  r_owned <= 1'b0;
            end else begin
              r_q            <= r_q + 2'd1;
              {r_scl, r_sda} <= quarter_levels(r_cmd, r_q + 2'd1, r_b, r_scl);
            end
            if (r_cmd == CMD_READ && r_q == Q1) r_bit <= w_sda_sync;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == IDLE);
  assign done_o      = r_done;
  assign bit_o       = r_bit;
  assign bus_owned_o = r_owned;
  assign scl_o       = r_scl;
  assign sda_o       = r_sda;

endmodule

// File: tb/tb_i2c_bit_controller.sv
// Directed bench for i2c_bit_controller: per-cycle vector table plus multi-cycle sequences.
module tb_i2c_bit_controller;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic       bit_in = 1'b0;
  logic       done;
  logic       bit_out;
  logic       bus_owned;
  logic       scl_o;
  logic       sda_o;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_bit_controller #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_i       (cmd),
    .bit_i       (bit_in),
    .done_o      (done),
    .bit_o       (bit_out),
    .bus_owned_o (bus_owned),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .scl_i       (scl_in),
    .sda_i       (sda_in)
  );

  // expected outputs packed as {scl, sda, ready, done, bit_o, bus_owned}
  typedef struct {
    logic       rst;
    logic       tk;
    logic       vld;
    logic [1:0] c;
    logic       b;
    logic       sdai;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic t, input logic v, input logic [1:0] c,
                              input logic b, input logic s, input logic [5:0] e);
    vec_t x;
    x.rst = r; x.tk = t; x.vld = v; x.c = c; x.b = b; x.sdai = s; x.exp = e;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Issues one command, then ticks every 'period' cycles until done_o; records level changes.
  task automatic run_cmd(input logic [1:0] c, input logic b, input int period,
                         output int nticks, output logic [7:0] trace, output bit got_done);
    logic [1:0] prev;
    prev      = {scl_o, sda_o};
    trace     = 8'h00;
    nticks    = 0;
    got_done  = 1'b0;
    cmd_valid = 1'b1;
    cmd       = c;
    bit_in    = b;
    step();
    cmd_valid = 1'b0;
    if ({scl_o, sda_o} != prev) begin
      trace = {trace[5:0], scl_o, sda_o};
      prev  = {scl_o, sda_o};
    end
    for (int i = 0; i < 200 && !got_done; i++) begin
      tick = ((i % period) == (period - 1));
      if (tick) nticks++;
      step();
      if ({scl_o, sda_o} != prev) begin
        trace = {trace[5:0], scl_o, sda_o};
        prev  = {scl_o, sda_o};
      end
      if (done) got_done = 1'b1;
    end
  endtask

  initial begin
    int         nt;
    logic [7:0] tr;
    bit         gd;
    int         dcnt;
    logic [7:0] wbits;
    logic [7:0] cap;
    int         k, nb, dones, ticks, cyc, unstable, late;
    logic       acc, prev_scl, prev_sda;

    // reset then idle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) dcnt++;
    end
    check("idle_done_pulses", dcnt, 0);
    check("idle_levels", {scl_o, sda_o, cmd_ready}, 3'b111);

    // per-cycle vector table
    vq.push_back(mk(1, 0, 0, CMD_START, 0, 1, 6'b111000));
    vq.push_back(mk(0, 0, 0, CMD_START, 0, 1, 6'b111000));
    vq.push_back(mk(0, 1, 0, CMD_START, 0, 1, 6'b111000));
    vq.push_back(mk(0, 1, 1, CMD_START, 0, 1, 6'b110000));
    vq.push_back(mk(0, 0, 0, CMD_START, 0, 1, 6'b110000));
    vq.push_back(mk(0, 1, 0, CMD_START, 0, 1, 6'b110000));
    vq.push_back(mk(0, 1, 0, CMD_START, 0, 1, 6'b100000));
    vq.push_back(mk(0, 0, 1, CMD_STOP,  0, 1, 6'b100000));
    vq.push_back(mk(0, 1, 0, CMD_START, 0, 1, 6'b000000));
    vq.push_back(mk(0, 1, 0, CMD_START, 0, 1, 6'b001101));
    vq.push_back(mk(0, 0, 1, CMD_WRITE, 1, 1, 6'b010001));
    vq.push_back(mk(0, 1, 0, CMD_WRITE, 0, 1, 6'b110001));
    vq.push_back(mk(0, 1, 0, CMD_WRITE, 0, 1, 6'b110001));
    vq.push_back(mk(0, 1, 0, CMD_WRITE, 0, 1, 6'b010001));
    vq.push_back(mk(0, 1, 0, CMD_WRITE, 0, 1, 6'b011101));
    vq.push_back(mk(0, 0, 1, CMD_READ,  0, 1, 6'b010001));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 1, 6'b110001));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 1, 6'b110011));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 1, 6'b010011));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 1, 6'b011111));
    vq.push_back(mk(0, 0, 1, CMD_READ,  0, 0, 6'b010011));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 0, 6'b110011));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 0, 6'b110001));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 0, 6'b010001));
    vq.push_back(mk(0, 1, 0, CMD_READ,  0, 0, 6'b011101));
    vq.push_back(mk(0, 0, 1, CMD_STOP,  0, 1, 6'b000001));
    vq.push_back(mk(0, 1, 0, CMD_STOP,  0, 1, 6'b100001));
    vq.push_back(mk(0, 1, 0, CMD_STOP,  0, 1, 6'b110001));
    vq.push_back(mk(0, 1, 0, CMD_STOP,  0, 1, 6'b110001));
    vq.push_back(mk(0, 1, 0, CMD_STOP,  0, 1, 6'b111100));
    vq.push_back(mk(0, 0, 0, CMD_STOP,  0, 1, 6'b111000));

    foreach (vq[i]) begin
      rst       = vq[i].rst;
      tick      = vq[i].tk;
      cmd_valid = vq[i].vld;
      cmd       = vq[i].c;
      bit_in    = vq[i].b;
      sda_in    = vq[i].sdai;
      step();
      cmd_valid = 1'b0;
      rst       = 1'b0;
      check($sformatf("vec%0d", i), {scl_o, sda_o, cmd_ready, done, bit_out, bus_owned},
            vq[i].exp);
    end

    // START from idle, tick every 5 cycles
    run_cmd(CMD_START, 1'b0, 5, nt, tr, gd);
    check("start_done", gd, 1);
    check("start_ticks", nt, 4);
    check("start_trace", tr, 8'h08);
    check("start_owned", bus_owned, 1);

    // eight back-to-back writes, each accepted in the previous done cycle
    wbits = 8'b10110010;
    cap = 8'h00; k = 0; nb = 0; dones = 0; ticks = 0; cyc = 0; unstable = 0; late = 0;
    prev_scl = scl_o; prev_sda = sda_o;
    cmd_valid = 1'b1; cmd = CMD_WRITE; bit_in = wbits[7];
    while (dones < 8 && cyc < 400) begin
      acc = cmd_valid && cmd_ready;
      if (acc && k > 0 && !done) late++;
      tick = ((cyc % 5) == 4);
      if (tick && !cmd_ready) ticks++;
      step();
      cyc++;
      if (acc) begin
        k++;
        if (k < 8) bit_in = wbits[7-k];
        else       cmd_valid = 1'b0;
      end
      if (done) dones++;
      if (scl_o && prev_scl && (sda_o != prev_sda)) unstable++;
      if (scl_o && !prev_scl && nb < 8) begin
        cap[7-nb] = sda_o;
        nb++;
      end
      prev_scl = scl_o; prev_sda = sda_o;
    end
    cmd_valid = 1'b0;
    check("wr_dones", dones, 8);
    check("wr_ticks", ticks, 32);
    check("wr_sda_stable", unstable, 0);
    check("wr_bits_on_bus", cap, wbits);
    check("wr_accept_on_done", late, 0);

    // repeated START with SCL low held through Q0
    run_cmd(CMD_START, 1'b0, 3, nt, tr, gd);
    check("rstart_done", gd, 1);
    check("rstart_trace", tr, 8'h78);

    // STOP
    run_cmd(CMD_STOP, 1'b0, 4, nt, tr, gd);
    check("stop_done", gd, 1);
    check("stop_trace", tr, 8'h0B);
    check("stop_final", {scl_o, sda_o, bus_owned}, 3'b110);

`ifdef I2C_CLOCK_STRETCH_EN
    // target holds SCL low in Q1: q must freeze until release
    scl_in = 1'b0;
    step(); step(); step();
    cmd_valid = 1'b1; cmd = CMD_START; bit_in = 1'b0;
    step();
    cmd_valid = 1'b0;
    tick = 1'b1; step();
    for (int i = 0; i < 12; i++) begin
      step(); step();
      tick = 1'b1; step();
    end
    check("stretch_frozen", {scl_o, sda_o, cmd_ready, done}, 4'b1100);
    scl_in = 1'b1;
    step(); step(); step();
    nt = 0; gd = 1'b0;
    for (int i = 0; i < 100 && !gd; i++) begin
      tick = ((i % 3) == 2);
      if (tick) nt++;
      step();
      if (done) gd = 1'b1;
    end
    check("stretch_done", gd, 1);
    check("stretch_ticks_after_release", nt, 3);
`else
    // SCL input is ignored: a low SCL does not hold the phase
    scl_in = 1'b0;
    step(); step(); step();
    run_cmd(CMD_START, 1'b0, 3, nt, tr, gd);
    check("nostretch_done", gd, 1);
    check("nostretch_ticks", nt, 4);
    scl_in = 1'b1;
`endif

    // reset during Q2 of a WRITE aborts without done
    cmd_valid = 1'b1; cmd = CMD_WRITE; bit_in = 1'b0;
    step();
    cmd_valid = 1'b0;
    tick = 1'b1; step();
    tick = 1'b1; step();
    check("abort_in_q2", {scl_o, sda_o, cmd_ready}, 3'b100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_reset_state", {scl_o, sda_o, cmd_ready, done, bus_owned}, 5'b11100);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      step();
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
